// File: rtl/xgmii_link_pipe.sv
// XGMII boundary stage: reset synchroniser, link qualification FSM and TX/RX retiming
// with ordered-set substitution. Optional remote-fault response: define XGMII_FAULT_RESP_EN.
module xgmii_link_pipe #(
  parameter int LANES         = 8,
  parameter int TX_STAGES     = 1,
  parameter int RX_STAGES     = 1,
  parameter int RST_STAGES    = 3,
  parameter int LINKUP_CYCLES = 1024,
  parameter int CNT_W         = 16,
  localparam int DATA_W       = 8 * LANES
) (
  input  logic              clk156,
  input  logic              reset,
  output logic              reset156,
  input  logic [DATA_W-1:0] xgmii_txd_in,
  input  logic [LANES-1:0]  xgmii_txc_in,
  output logic [DATA_W-1:0] xgmii_txd_out,
  output logic [LANES-1:0]  xgmii_txc_out,
  input  logic [DATA_W-1:0] xgmii_rxd_in,
  input  logic [LANES-1:0]  xgmii_rxc_in,
  output logic [DATA_W-1:0] xgmii_rxd_out,
  output logic [LANES-1:0]  xgmii_rxc_out,
  input  logic              align_status,
  input  logic [3:0]        sync_status,
  input  logic              mgt_tx_ready,
  input  logic              clear_cnt,
  output logic              link_up,
  output logic [CNT_W-1:0]  link_drop_cnt
);
  localparam int CW = $clog2(LINKUP_CYCLES) + 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(LINKUP_CYCLES - 1);
  localparam logic [DATA_W-1:0] IDLE_D   = {LANES{8'h07}};
  localparam logic [LANES-1:0]  IDLE_C   = '1;
  localparam logic [DATA_W-1:0] LF_D     = {(LANES / 4){32'h0100_009C}};
  localparam logic [LANES-1:0]  FAULT_C  = {(LANES / 4){4'b0001}};

  typedef enum logic [1:0] {ST_DOWN, ST_WAIT, ST_UP} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [RST_STAGES-1:0] rst_chain;
  state_t                state, state_next;
  logic [CW-1:0]         wait_cnt, wait_cnt_next;
  logic                  qual, drop;

  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) rst_chain <= '1;
    else       rst_chain <= {rst_chain[RST_STAGES-2:0], 1'b0};
  end
  assign reset156 = rst_chain[RST_STAGES-1];

  assign qual = align_status & (&sync_status) & mgt_tx_ready;

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    drop          = 1'b0;
    case (state)
      ST_DOWN: if (qual) begin
        state_next    = ST_WAIT;
        wait_cnt_next = '0;
      end
      ST_WAIT: begin
        if (!qual)                     state_next    = ST_DOWN;
        else if (wait_cnt == CNT_LAST) state_next    = ST_UP;
        else                           wait_cnt_next = wait_cnt + CW'(1);
      end
      ST_UP: if (!qual) begin
        state_next = ST_DOWN;
        drop       = 1'b1;
      end
      default: state_next = ST_DOWN;
    endcase
  end

  // link_up is registered alongside the state so it equals (state == UP) without a decode lag
  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) begin
      state         <= ST_DOWN;
      wait_cnt      <= '0;
      link_up       <= 1'b0;
      link_drop_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      link_up  <= (state_next == ST_UP);
      if (clear_cnt) link_drop_cnt <= '0;
      else if (drop) link_drop_cnt <= sat_inc(link_drop_cnt);
    end
  end

  logic [TX_STAGES-1:0][DATA_W-1:0] tx_d;
  logic [TX_STAGES-1:0][LANES-1:0]  tx_c;
  logic [RX_STAGES-1:0][DATA_W-1:0] rx_d;
  logic [RX_STAGES-1:0][LANES-1:0]  rx_c;
  logic [DATA_W-1:0] tx_pre_d, tx_fin_d, rx_pre_d, rx_fin_d;
  logic [LANES-1:0]  tx_pre_c, tx_fin_c, rx_pre_c, rx_fin_c;

  if (TX_STAGES == 1) begin : g_tx_one
    assign tx_pre_d = xgmii_txd_in;
    assign tx_pre_c = xgmii_txc_in;
  end else begin : g_tx_many
    assign tx_pre_d = tx_d[TX_STAGES-2];
    assign tx_pre_c = tx_c[TX_STAGES-2];
  end

  if (RX_STAGES == 1) begin : g_rx_one
    assign rx_pre_d = xgmii_rxd_in;
    assign rx_pre_c = xgmii_rxc_in;
  end else begin : g_rx_many
    assign rx_pre_d = rx_d[RX_STAGES-2];
    assign rx_pre_c = rx_c[RX_STAGES-2];
  end

`ifdef XGMII_FAULT_RESP_EN
  localparam logic [DATA_W-1:0] RF_D = {(LANES / 4){32'h0200_009C}};

  function automatic logic is_lf(input logic [31:0] d, input logic [3:0] c);
    return (d == 32'h0100_009C) && (c == 4'b0001);
  endfunction

  logic [6:0] rf_cnt;
  logic       rx_lf;

  assign rx_lf = is_lf(xgmii_rxd_in[31:0], xgmii_rxc_in[3:0]) ||
                 ((LANES == 8) && is_lf(xgmii_rxd_in[DATA_W-1 -: 32], xgmii_rxc_in[LANES-1 -: 4]));

  always_ff @(posedge clk156 or posedge reset) begin
    if (reset)                 rf_cnt <= '0;
    else if (link_up && rx_lf) rf_cnt <= 7'd127;
    else if (rf_cnt != 7'd0)   rf_cnt <= rf_cnt - 7'd1;
  end

  // Remote fault only overrides MAC data; a down link always sends idle
  assign tx_fin_d = !link_up ? IDLE_D : (rf_cnt != 7'd0) ? RF_D    : tx_pre_d;
  assign tx_fin_c = !link_up ? IDLE_C : (rf_cnt != 7'd0) ? FAULT_C : tx_pre_c;
`else
  assign tx_fin_d = link_up ? tx_pre_d : IDLE_D;
  assign tx_fin_c = link_up ? tx_pre_c : IDLE_C;
`endif

  assign rx_fin_d = link_up ? rx_pre_d : LF_D;
  assign rx_fin_c = link_up ? rx_pre_c : FAULT_C;

  // Final stage overwrites the shift for the last index, keeping substitution column-atomic
  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) begin
      tx_d <= {TX_STAGES{IDLE_D}};
      tx_c <= {TX_STAGES{IDLE_C}};
      rx_d <= {RX_STAGES{LF_D}};
      rx_c <= {RX_STAGES{FAULT_C}};
    end else begin
      tx_d[0] <= xgmii_txd_in;
      tx_c[0] <= xgmii_txc_in;
      for (int i = 1; i < TX_STAGES - 1; i++) begin
        tx_d[i] <= tx_d[i-1];
        tx_c[i] <= tx_c[i-1];
      end
      tx_d[TX_STAGES-1] <= tx_fin_d;
      tx_c[TX_STAGES-1] <= tx_fin_c;
      rx_d[0] <= xgmii_rxd_in;
      rx_c[0] <= xgmii_rxc_in;
      for (int i = 1; i < RX_STAGES - 1; i++) begin
        rx_d[i] <= rx_d[i-1];
        rx_c[i] <= rx_c[i-1];
      end
      rx_d[RX_STAGES-1] <= rx_fin_d;
      rx_c[RX_STAGES-1] <= rx_fin_c;
    end
  end

  assign xgmii_txd_out = tx_d[TX_STAGES-1];
  assign xgmii_txc_out = tx_c[TX_STAGES-1];
  assign xgmii_rxd_out = rx_d[RX_STAGES-1];
  assign xgmii_rxc_out = rx_c[RX_STAGES-1];
endmodule

// File: tb/tb_xgmii_link_pipe.sv
// Self-checking bench for xgmii_link_pipe: vector table, hand sequences and a randomized
// run against a rule-level reference model (link = enough consecutive qualified samples).
module tb_xgmii_link_pipe;
  localparam int LANES = 8;
  localparam int TXS   = 2;
  localparam int RXS   = 3;
  localparam int LUC   = 16;
  localparam int CW    = 4;
  localparam int SAT   = (1 << CW) - 1;

  localparam logic [63:0] IDLE_D = 64'h0707070707070707;
  localparam logic [7:0]  IDLE_C = 8'hFF;
  localparam logic [63:0] LF_D   = 64'h0100009C0100009C;
  localparam logic [7:0]  LF_C   = 8'h11;
  localparam logic [63:0] RF_D   = 64'h0200009C0200009C;

  logic          clk156 = 1'b0;
  logic          reset  = 1'b0;
  logic          reset156;
  logic [63:0]   txd_in = '0, txd_out, rxd_in = '0, rxd_out;
  logic [7:0]    txc_in = '0, txc_out, rxc_in = '0, rxc_out;
  logic          align_status = 1'b0, mgt_tx_ready = 1'b0, clear_cnt = 1'b0;
  logic [3:0]    sync_status = '0;
  logic          link_up;
  logic [CW-1:0] link_drop_cnt;

  always #5 clk156 = ~clk156;

  xgmii_link_pipe #(
    .LANES(LANES), .TX_STAGES(TXS), .RX_STAGES(RXS), .RST_STAGES(3),
    .LINKUP_CYCLES(LUC), .CNT_W(CW)
  ) dut (
    .clk156(clk156), .reset(reset), .reset156(reset156),
    .xgmii_txd_in(txd_in), .xgmii_txc_in(txc_in),
    .xgmii_txd_out(txd_out), .xgmii_txc_out(txc_out),
    .xgmii_rxd_in(rxd_in), .xgmii_rxc_in(rxc_in),
    .xgmii_rxd_out(rxd_out), .xgmii_rxc_out(rxc_out),
    .align_status(align_status), .sync_status(sync_status),
    .mgt_tx_ready(mgt_tx_ready), .clear_cnt(clear_cnt),
    .link_up(link_up), .link_drop_cnt(link_drop_cnt)
  );

  typedef struct { logic [63:0] d; logic [7:0] c; } col_t;
  typedef struct { logic align; logic [3:0] sync; logic mgt; int cycles; logic exp_up; } vec_t;

  col_t tx_hist[$];
  col_t rx_hist[$];
  int   m_run, m_drops, m_rf;
  bit   m_up;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [63:0] exp_txd, exp_rxd;
  logic [7:0]  exp_txc, exp_rxc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit col_is_lf(input logic [63:0] d, input logic [7:0] c);
    return (d[31:0] == 32'h0100009C && c[3:0] == 4'b0001) ||
           (d[63:32] == 32'h0100009C && c[7:4] == 4'b0001);
  endfunction

  function automatic logic [63:0] pat(input int i);
    return 64'(i) * 64'h0101010101010101 + 64'h0011223344556677;
  endfunction

  task automatic model_reset();
    tx_hist.delete();
    rx_hist.delete();
    m_run = 0; m_drops = 0; m_rf = 0; m_up = 1'b0;
  endtask

  // One clock: update the model from the inputs sampled at this edge, then compare.
  task automatic step();
    bit q, up_before;
    @(posedge clk156);
    up_before = m_up;
    q = align_status && (&sync_status) && mgt_tx_ready;
    tx_hist.push_front('{txd_in, txc_in});
    rx_hist.push_front('{rxd_in, rxc_in});
    if (tx_hist.size() > 8) void'(tx_hist.pop_back());
    if (rx_hist.size() > 8) void'(rx_hist.pop_back());
    exp_txd = IDLE_D; exp_txc = IDLE_C;
    if (up_before && tx_hist.size() >= TXS) begin
      exp_txd = tx_hist[TXS-1].d; exp_txc = tx_hist[TXS-1].c;
    end
`ifdef XGMII_FAULT_RESP_EN
    if (up_before && m_rf != 0) begin exp_txd = RF_D; exp_txc = LF_C; end
    if (up_before && col_is_lf(rxd_in, rxc_in)) m_rf = 127;
    else if (m_rf > 0) m_rf--;
`endif
    exp_rxd = LF_D; exp_rxc = LF_C;
    if (up_before && rx_hist.size() >= RXS) begin
      exp_rxd = rx_hist[RXS-1].d; exp_rxc = rx_hist[RXS-1].c;
    end
    if (clear_cnt) m_drops = 0;
    else if (up_before && !q && m_drops < SAT) m_drops++;
    m_run = q ? m_run + 1 : 0;
    m_up  = (m_run >= LUC + 1);
    #1;
    chk("txd", txd_out, exp_txd);
    chk("txc", 64'(txc_out), 64'(exp_txc));
    chk("rxd", rxd_out, exp_rxd);
    chk("rxc", 64'(rxc_out), 64'(exp_rxc));
    chk("link_up", 64'(link_up), 64'(m_up));
    chk("drop_cnt", 64'(link_drop_cnt), 64'(m_drops));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic set_qual(input bit on);
    align_status = on;
    sync_status  = on ? 4'hF : 4'h0;
    mgt_tx_ready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_txd"}, txd_out, IDLE_D);
    chk({tag, "_txc"}, 64'(txc_out), 64'(IDLE_C));
    chk({tag, "_rxd"}, rxd_out, LF_D);
    chk({tag, "_rxc"}, 64'(rxc_out), 64'(LF_C));
    chk({tag, "_link_up"}, 64'(link_up), 64'd0);
    chk({tag, "_drop_cnt"}, 64'(link_drop_cnt), 64'd0);
    chk({tag, "_reset156"}, 64'(reset156), 64'd1);
  endtask

  initial begin
    vec_t vecs[7];
    int   saved, n;
    vecs[0] = '{1'b1, 4'hF, 1'b1, 17, 1'b1};
    vecs[1] = '{1'b1, 4'hF, 1'b1, 16, 1'b0};
    vecs[2] = '{1'b0, 4'hF, 1'b1, 17, 1'b0};
    vecs[3] = '{1'b1, 4'hE, 1'b1, 17, 1'b0};
    vecs[4] = '{1'b1, 4'h7, 1'b1, 17, 1'b0};
    vecs[5] = '{1'b1, 4'hF, 1'b0, 17, 1'b0};
    vecs[6] = '{1'b1, 4'hF, 1'b1, 20, 1'b1};

    // Reset release
    #1 reset = 1'b1;
    repeat (5) @(posedge clk156);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    model_reset();
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("reset156_release", 64'(reset156), (k < 3) ? 64'd1 : 64'd0);
    end

    // Qualification / debounce vector table
    foreach (vecs[i]) begin
      set_qual(1'b0);
      step();
      align_status = vecs[i].align;
      sync_status  = vecs[i].sync;
      mgt_tx_ready = vecs[i].mgt;
      run(vecs[i].cycles);
      chk("vec_link_up", 64'(link_up), 64'(vecs[i].exp_up));
    end

    // Debounce aborted at cycle 10, restart needs the full 17
    set_qual(1'b0); step();
    set_qual(1'b1); run(10);
    set_qual(1'b0); step();
    set_qual(1'b1); run(16);
    chk("restart_not_yet", 64'(link_up), 64'd0);
    step();
    chk("restart_up", 64'(link_up), 64'd1);

    // Pass-through with incrementing patterns
    for (int i = 0; i < 30; i++) begin
      txd_in = pat(i);  txc_in = 8'(i);
      rxd_in = ~pat(i); rxc_in = 8'(i * 3);
      step();
      if (i >= 2) begin
        chk("pt_txd", txd_out, pat(i - 1));
        chk("pt_txc", 64'(txc_out), 64'(8'(i - 1)));
        chk("pt_rxd", rxd_out, ~pat(i - 2));
        chk("pt_rxc", 64'(rxc_out), 64'(8'((i - 2) * 3)));
      end
    end

    // Single-cycle sync loss while up
    saved = m_drops;
    sync_status = 4'b1011;
    step();
    chk("drop_link_up", 64'(link_up), 64'd0);
    chk("drop_cnt_inc", 64'(link_drop_cnt), 64'(saved + 1));
    sync_status = 4'hF;
    step();
    chk("drop_txd_idle", txd_out, IDLE_D);
    chk("drop_rxd_lf", rxd_out, LF_D);

    // Saturation of the drop counter, then clear beating a simultaneous drop
    for (int i = 0; i < SAT + 2; i++) begin
      set_qual(1'b1); run(18);
      set_qual(1'b0); step();
    end
    chk("drop_cnt_sat", 64'(link_drop_cnt), 64'(SAT));
    set_qual(1'b1); run(18);
    set_qual(1'b0); clear_cnt = 1'b1; step();
    clear_cnt = 1'b0;
    chk("clear_with_drop", 64'(link_drop_cnt), 64'd0);

`ifdef XGMII_FAULT_RESP_EN
    set_qual(1'b1); rxd_in = pat(7); rxc_in = 8'h00; run(18);
    rxd_in = LF_D; rxc_in = LF_C; step();
    rxd_in = pat(9); rxc_in = 8'h00;
    n = 0;
    for (int i = 0; i < 140; i++) begin
      txd_in = pat(100 + i); txc_in = 8'h00;
      step();
      if (txd_out == RF_D && txc_out == LF_C) n++;
    end
    chk("rf_columns", 64'(n), 64'd127);
`endif

    // Randomized traffic with occasional qualification loss and counter clears
    for (int i = 0; i < 2500; i++) begin
      txd_in = {$urandom, $urandom}; txc_in = 8'($urandom);
      rxd_in = {$urandom, $urandom}; rxc_in = 8'($urandom);
      align_status = ($urandom_range(0, 1499) != 0);
      for (int b = 0; b < 4; b++) sync_status[b] = ($urandom_range(0, 1499) != 0);
      mgt_tx_ready = ($urandom_range(0, 1499) != 0);
      clear_cnt    = ($urandom_range(0, 499) == 0);
      step();
    end
    clear_cnt = 1'b0;

    // Async reset mid-frame, with a non-zero drop count beforehand
    set_qual(1'b1); run(18);
    set_qual(1'b0); step();
    set_qual(1'b1); run(18);
    for (int i = 0; i < 3; i++) begin
      txd_in = pat(200 + i); rxd_in = pat(300 + i); step();
    end
    chk("pre_reset_up", 64'(link_up), 64'd1);
    #3 reset = 1'b1;
    #1;
    check_reset_outputs("async");
    repeat (3) @(posedge clk156);
    #1 reset = 1'b0;
    model_reset();
    run(5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
